mem_port_arbiter: RTL and testbench

- Sequences and shares one single-port data memory between two requesters: port 0 (instruction fetch) and port 1 (load/store stage).
- Uses a per-port req/ack handshake and a fixed-latency access counter.
- Drives the memory's enable, write-enable, address and write-data inputs.
- Captures read data and returns it to the granted requester.
- Sits between the pipeline's fetch/MEM stages and the memory block.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Sequences one single-port memory between fetch (port 0) and load/store (port 1) with a
// fixed-latency access. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_ack_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              grant_o
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_any_req;
    logic              w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              r_last;
`endif

    always_comb begin
        w_any_req = p0_req_i | p1_req_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the port that did not win last time goes first.
        if (p0_req_i && p1_req_i) begin
            w_win = ~r_last;
        end else begin
            w_win = p1_req_i;
        end
`else
        w_win = p1_req_i;
`endif
        w_win_we    = w_win ? p1_we_i    : p0_we_i;
        w_win_addr  = w_win ? p1_addr_i  : p0_addr_i;
        w_win_wdata = w_win ? p1_wdata_i : p0_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            p0_ack_o    <= 1'b0;
            p1_ack_o    <= 1'b0;
            rdata_o     <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            grant_o     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last      <= 1'b1;
`endif
        end else begin
            p0_ack_o <= 1'b0;
            p1_ack_o <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        grant_o     <= w_win;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= w_win_we;
                        mem_addr_o  <= w_win_addr;
                        mem_wdata_o <= w_win_wdata;
                        r_cnt       <= CNT_LOAD;
                        busy_o      <= 1'b1;
                        r_state     <= StAccess;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last      <= w_win;
`endif
                    end
                end
                StAccess: begin
                    if (r_cnt == '0) begin
                        // Memory data is valid in this last access cycle.
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        mem_en_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        p0_ack_o <= ~grant_o;
                        p1_ack_o <= grant_o;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    busy_o  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy, grant;

    logic        l1_req, l1_ack0, l1_ack1, l1_mem_en, l1_mem_we, l1_busy, l1_grant;
    logic [31:0] l1_addr, l1_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_ack_o(p0_ack),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack),
        .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy), .grant_o(grant)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_lat1 (
        .clk_i(clk), .rst_i(rst_n),
        .p0_req_i(l1_req), .p0_we_i(1'b0), .p0_addr_i(l1_addr), .p0_wdata_i(32'h0),
        .p0_ack_o(l1_ack0),
        .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(32'h0), .p1_wdata_i(32'h0),
        .p1_ack_o(l1_ack1),
        .rdata_o(l1_rdata), .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we),
        .mem_addr_o(l1_mem_addr), .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata),
        .busy_o(l1_busy), .grant_o(l1_grant)
    );

    function automatic logic [31:0] mem_init_val(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
    endfunction

    // Environment memory: data only presented while the arbiter enables it.
    logic [31:0] env_mem [64];
    logic        init_mem;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= mem_init_val(i);
        end else if (mem_en && mem_we) begin
            env_mem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata    = mem_en ? env_mem[mem_addr[5:0]] : 32'h0BAD_F00D;
    assign l1_mem_rdata = l1_mem_en ? (32'h5A00_0000 | l1_mem_addr) : 32'h0BAD_F00D;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        l1_req = 1'b0; l1_addr = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n    = 1'b0;
        init_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic set_req(input int p, input logic req);
        if (p == 0) begin
            p0_req = req; p0_we = ($urandom_range(1) != 0);
            p0_addr = 32'($urandom_range(31)); p0_wdata = $urandom;
        end else begin
            p1_req = req; p1_we = ($urandom_range(1) != 0);
            p1_addr = 32'($urandom_range(31)); p1_wdata = $urandom;
        end
    endtask

    // inp = {p0_req, p0_we, p1_req, p1_we}; ex = {ack0, ack1, en, we, busy, grant}
    typedef struct {
        logic [3:0]  inp;
        logic [31:0] a0, d0, a1, d1;
        logic [5:0]  ex;
        logic [31:0] rd, ad, wd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] inp, input logic [31:0] a0, d0, a1, d1,
                       input logic [5:0] ex, input logic [31:0] rd, ad, wd);
        vec_t v;
        v.inp = inp; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.ex = ex; v.rd = rd; v.ad = ad; v.wd = wd;
        tbl.push_back(v);
    endtask

    // Transaction-level reference model state
    int          g, next_free, nacks, rem0, rem1, lat;
    bit          have, t_port, t_we, rr_last, win;
    bit          e_en, e_busy, e_ack0, e_ack1;
    logic [31:0] t_addr, t_wdata, t_rd, m_rdata, m_addr, m_wdata;
    bit          m_grant;
    logic [31:0] m_mem [64];
    bit          pend [2];
    bit          rel [2];
    int          ack_port [4];
    int          ack_cyc [4];
    int          exp_port [3];
    int          exp_cyc [3];
    int          exp_n;

    initial begin
        // Single p0 read of 0x10, then p1 write 0xA5 to 0x4 and read it back
        add(4'b1000, 32'h10, 32'h1111_1111, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            add(4'b1000, 32'h10, 32'h1111_1111, 32'h0, 32'h0, 6'b001010, 32'h0, 32'h10,
                32'h1111_1111);
        add(4'b1000, 32'h10, 32'h1111_1111, 32'h0, 32'h0, 6'b100010, 32'hDEAD_BEEF, 32'h10,
            32'h1111_1111);
        add(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'hDEAD_BEEF, 32'h10,
            32'h1111_1111);
        add(4'b0011, 32'h0, 32'h0, 32'h4, 32'hA5, 6'b000000, 32'hDEAD_BEEF, 32'h10,
            32'h1111_1111);
        for (int i = 0; i < 4; i++)
            add(4'b0011, 32'h0, 32'h0, 32'h4, 32'hA5, 6'b001111, 32'hDEAD_BEEF, 32'h4, 32'hA5);
        add(4'b0011, 32'h0, 32'h0, 32'h4, 32'hA5, 6'b010011, 32'hDEAD_BEEF, 32'h4, 32'hA5);
        add(4'b0010, 32'h0, 32'h0, 32'h4, 32'h0, 6'b000001, 32'hDEAD_BEEF, 32'h4, 32'hA5);
        for (int i = 0; i < 4; i++)
            add(4'b0010, 32'h0, 32'h0, 32'h4, 32'h0, 6'b001011, 32'hDEAD_BEEF, 32'h4, 32'h0);
        add(4'b0010, 32'h0, 32'h0, 32'h4, 32'h0, 6'b010011, 32'hA5, 32'h4, 32'h0);
        add(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'b000001, 32'hA5, 32'h4, 32'h0);

        // Reset values
        drive_idle();
        rst_n    = 1'b0;
        init_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst ack0", p0_ack, 1'b0);
        chk1("rst ack1", p1_ack, 1'b0);
        chk1("rst en", mem_en, 1'b0);
        chk1("rst we", mem_we, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst grant", grant, 1'b0);
        chk32("rst rdata", rdata, 32'h0);
        chk32("rst addr", mem_addr, 32'h0);
        chk32("rst wdata", mem_wdata, 32'h0);
        init_mem = 1'b0;
        rst_n    = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            chk1($sformatf("row%0d ack0", i), p0_ack, tbl[i].ex[5]);
            chk1($sformatf("row%0d ack1", i), p1_ack, tbl[i].ex[4]);
            chk1($sformatf("row%0d en", i), mem_en, tbl[i].ex[3]);
            chk1($sformatf("row%0d we", i), mem_we, tbl[i].ex[2]);
            chk1($sformatf("row%0d busy", i), busy, tbl[i].ex[1]);
            chk1($sformatf("row%0d grant", i), grant, tbl[i].ex[0]);
            chk32($sformatf("row%0d rdata", i), rdata, tbl[i].rd);
            chk32($sformatf("row%0d addr", i), mem_addr, tbl[i].ad);
            chk32($sformatf("row%0d wdata", i), mem_wdata, tbl[i].wd);
            p0_req = tbl[i].inp[3]; p0_we = tbl[i].inp[2];
            p1_req = tbl[i].inp[1]; p1_we = tbl[i].inp[0];
            p0_addr = tbl[i].a0; p0_wdata = tbl[i].d0;
            p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
        end
        drive_idle();

        // Idle: nothing moves without requests
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            chk1("idle busy", busy, 1'b0);
            chk1("idle en", mem_en, 1'b0);
            chk1("idle ack0", p0_ack, 1'b0);
            chk1("idle ack1", p1_ack, 1'b0);
        end

        // Simultaneous requests from reset, both held until their last ack
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rem0 = 2; exp_n = 3;
        exp_port[0] = 0; exp_cyc[0] = LAT + 1;
        exp_port[1] = 1; exp_cyc[1] = 2 * LAT + 3;
        exp_port[2] = 0; exp_cyc[2] = 3 * LAT + 5;
`else
        rem0 = 1; exp_n = 2;
        exp_port[0] = 1; exp_cyc[0] = LAT + 1;
        exp_port[1] = 0; exp_cyc[1] = 2 * LAT + 3;
        exp_port[2] = 0; exp_cyc[2] = 0;
`endif
        rem1 = 1; nacks = 0;
        for (int i = 0; i < 4; i++) begin ack_port[i] = 9; ack_cyc[i] = -1; end
        for (int n = 0; n < 26; n++) begin
            @(posedge clk);
            #1;
            p0_req = (rem0 > 0); p0_addr = 32'h2;
            p1_req = (rem1 > 0); p1_addr = 32'h3;
            if (p0_ack && nacks < 4) begin
                ack_port[nacks] = 0; ack_cyc[nacks] = n; nacks++; rem0--;
            end
            if (p1_ack && nacks < 4) begin
                ack_port[nacks] = 1; ack_cyc[nacks] = n; nacks++; rem1--;
            end
        end
        drive_idle();
        chk32("tie ack count", 32'(nacks), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk32($sformatf("tie ack%0d port", i), 32'(ack_port[i]), 32'(exp_port[i]));
            chk32($sformatf("tie ack%0d cycle", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
        end

        // Asynchronous reset in ACCESS cycle 2 aborts the read
        @(posedge clk);
        #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        @(posedge clk);
        #1;
        chk1("abort access1 en", mem_en, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk1("abort en", mem_en, 1'b0);
        chk1("abort we", mem_we, 1'b0);
        chk1("abort busy", busy, 1'b0);
        chk1("abort ack0", p0_ack, 1'b0);
        chk1("abort grant", grant, 1'b0);
        chk32("abort rdata", rdata, 32'h0);
        chk32("abort addr", mem_addr, 32'h0);
        p0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            chk1("post-abort ack0", p0_ack, 1'b0);
            chk1("post-abort busy", busy, 1'b0);
        end
        @(posedge clk);
        #1;
        p0_req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (p0_ack) begin
                lat = k;
                break;
            end
        end
        chk32("rerequest latency", 32'(lat), 32'(LAT + 1));
        chk32("rerequest rdata", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive_idle();

        // LAT=1 instance: back-to-back reads of addr 0 and addr 1
        for (int n = 0; n < 9; n++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("lat1 c%0d en", n), l1_mem_en, (n == 1 || n == 4));
            chk1($sformatf("lat1 c%0d ack", n), l1_ack0, (n == 2 || n == 5));
            chk1($sformatf("lat1 c%0d busy", n), l1_busy, (n inside {1, 2, 4, 5}));
            chk32($sformatf("lat1 c%0d rdata", n), l1_rdata,
                  (n < 2) ? 32'h0 : (n < 5) ? 32'h5A00_0000 : 32'h5A00_0001);
            l1_req  = (n <= 5);
            l1_addr = (n <= 2) ? 32'h0 : 32'h1;
        end
        drive_idle();

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = mem_init_val(i);
        m_rdata = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_grant = 1'b0;
        have = 1'b0; g = 0; next_free = 0; rr_last = 1'b1;
        t_port = 1'b0; t_we = 1'b0; t_addr = 32'h0; t_wdata = 32'h0; t_rd = 32'h0;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; rel[p] = 1'b0; end
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            e_en   = have && n >= g + 1 && n <= g + LAT;
            e_busy = have && n >= g + 1 && n <= g + LAT + 1;
            e_ack0 = have && n == g + LAT + 1 && !t_port;
            e_ack1 = have && n == g + LAT + 1 && t_port;
            if (have && n == g + LAT + 1 && !t_we) m_rdata = t_rd;
            chk1("rnd ack0", p0_ack, e_ack0);
            chk1("rnd ack1", p1_ack, e_ack1);
            chk1("rnd en", mem_en, e_en);
            chk1("rnd we", mem_we, e_en && t_we);
            chk1("rnd busy", busy, e_busy);
            chk1("rnd grant", grant, m_grant);
            chk32("rnd rdata", rdata, m_rdata);
            chk32("rnd addr", mem_addr, m_addr);
            chk32("rnd wdata", mem_wdata, m_wdata);
            for (int p = 0; p < 2; p++) begin
                if (rel[p]) begin
                    rel[p] = 1'b0;
                    pend[p] = ($urandom_range(1) != 0);
                    set_req(p, pend[p]);
                end else if (!pend[p]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[p] = 1'b1;
                        set_req(p, 1'b1);
                    end
                end else if (!(have && int'(t_port) == p && n <= g + LAT + 1) &&
                             $urandom_range(3) == 0) begin
                    set_req(p, 1'b1);
                end
                if ((p == 0 && e_ack0) || (p == 1 && e_ack1)) begin
                    pend[p] = 1'b0;
                    rel[p]  = 1'b1;
                end
            end
            if (n >= next_free && (p0_req || p1_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = (p0_req && p1_req) ? !rr_last : p1_req;
`else
                win = p1_req;
`endif
                have = 1'b1; g = n; t_port = win;
                t_we    = win ? p1_we : p0_we;
                t_addr  = win ? p1_addr : p0_addr;
                t_wdata = win ? p1_wdata : p0_wdata;
                if (t_we) m_mem[t_addr[5:0]] = t_wdata;
                else t_rd = m_mem[t_addr[5:0]];
                m_addr = t_addr; m_wdata = t_wdata; m_grant = win; rr_last = win;
                next_free = n + LAT + 2;
            end
        end
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
